uart_packet_ctl: RTL and testbench
==================================

Name: uart_packet_ctl

Overview:
- Parametrised successor of the single-byte UART controller.
- Transmits and receives fixed-length multi-byte frames over one UART link, with a sync header and an XOR checksum.
- Adds framing, integrity checking, an inter-byte timeout and an optional auto-repeat TX mode.
- Sits between game logic (e.g. player-state exchange between two boards) and the existing `uart` core (baud generator, RX/TX, FIFOs).

Parameters:
- NBYTES, 4: payload bytes per frame (1..16).
- HEADER, 8'hA5: sync byte sent before every payload.
- DVSR, 54: baud divisor passed to `uart`.
- DVSR_BIT, 7: divisor counter width passed to `uart`.
- FIFO_W, 2: `uart` FIFO address width.
- AUTO_TX, 0: 1 = start a new frame whenever the TX FSM is idle; tx_start is ignored.
- TIMEOUT_CYC, 20000: clk cycles allowed between RX bytes inside a frame.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- rx  in  1  UART serial input
- tx  out  1  UART serial output (registered)
- tx_data  in  8*NBYTES  payload to send; byte k = tx_data[8k+7:8k]
- tx_start  in  1  request one frame (AUTO_TX=0)
- tx_busy  out  1  frame in progress
- rx_data  out  8*NBYTES  last good received payload
- rx_valid  out  1  one-cycle pulse: rx_data updated
- rx_err  out  1  one-cycle pulse: checksum fail or timeout

Interface rule: reset rst, synchronous, active-high; clock clk.

Behaviour:
Reset:
- tx = 1 (line idle), tx_busy = 0, rx_data = 0, rx_valid = 0, rx_err = 0.
- Both FSMs return to their initial state; the timeout counter is cleared.
- Reset mid-frame abandons the frame; no partial update of rx_data.

TX FSM (T_IDLE, T_HDR, T_PAY, T_CSUM):
- T_IDLE: tx_start=1 (or AUTO_TX=1) latches tx_data into a shadow register, clears running checksum csum_tx, goes to T_HDR. tx_busy=1 from the next cycle.
- wr_uart pulses for one cycle with w_data only when tx_full=0. If tx_full=1, the FSM stalls with no write and no lost byte.
- T_HDR writes HEADER, then T_PAY.
- T_PAY writes bytes 0..NBYTES-1, LSB byte first, and XORs each into csum_tx. After byte NBYTES-1 it goes to T_CSUM.
- T_CSUM writes csum_tx, then T_IDLE with tx_busy=0 in the same cycle.
- tx_start while tx_busy=1 is ignored (no queueing).
- Changes to tx_data during a frame do not affect the frame in flight.
- tx = registered copy of the `uart` tx output (1-cycle delay).

RX FSM (R_HUNT, R_PAY, R_CSUM):
- rd_uart = !rx_empty. A byte is consumed in each cycle rd_uart=1, using r_data from the FIFO head.
- R_HUNT: bytes other than HEADER are discarded. HEADER sets byte index to 0, clears csum_rx, goes to R_PAY.
- R_PAY: byte stored at index, index++, csum_rx ^= byte. HEADER values here are plain data. After NBYTES bytes, goes to R_CSUM.
- R_CSUM, byte == csum_rx: rx_data loaded from the assembly buffer and rx_valid=1 on the next cycle.
- R_CSUM, mismatch: rx_err=1 on the next cycle, rx_data unchanged.
- Both outcomes return to R_HUNT.

Timeout:
- Counter runs in R_PAY/R_CSUM, reset on every consumed byte, saturating.
- Reaching TIMEOUT_CYC: R_HUNT, rx_err pulse, buffer discarded.
- Byte arrival and timeout in the same cycle: the byte wins.

General:
- rx_valid and rx_err are never both 1 in the same cycle.
- Index and counter widths come from $clog2; no wrap beyond NBYTES.

Decomposition:
- Package uart_pkg: tx_state_t and rx_state_t enums, default HEADER constant, function xor_bytes(payload, n).
- Sub-module uart_frame_rx: RX FSM, assembly buffer and timeout.
- TX FSM stays in the top level alongside the existing `uart` instance.

Test Plan:
1. NBYTES=4, tx_data=32'h12345678, tx_start pulse → serial bytes A5,78,56,34,12,08; tx_busy high until the 08 write.
2. Loopback tx→rx, same frame → one rx_valid pulse, rx_data=32'h12345678, rx_err=0.
3. Inject A5,01,02,03,04,FF (good checksum 04) → rx_err pulse, rx_data unchanged.
4. Inject 00,A5,A5,A5,A5,A5,00 → garbage byte skipped; payload A5A5A5A5 accepted, rx_valid pulse.
5. Inject A5,11,22 then idle > TIMEOUT_CYC → rx_err pulse; next good frame accepted normally.
6. Assert rst mid-TX and mid-RX → tx=1, tx_busy=0, outputs zero; tx_start while busy produces no second frame; AUTO_TX=1 gives back-to-back frames.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the framed UART controller and its serial core.
package uart_pkg;

   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_HDR  = 2'd1,
      T_PAY  = 2'd2,
      T_CSUM = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      R_HUNT = 2'd0,
      R_PAY  = 2'd1,
      R_CSUM = 2'd2
   } rx_state_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } ser_state_t;

   localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
   localparam int         MAX_NBYTES     = 16;

   // XOR of the first n bytes of a payload (byte k at bits 8k+7:8k).
   function automatic logic [7:0] xor_bytes(input logic [8*MAX_NBYTES-1:0] payload, input int n);
      logic [7:0] acc;
      acc = 8'h00;
      for (int k = 0; k < MAX_NBYTES; k++) begin
         if (k < n) begin
            acc = acc ^ payload[8*k +: 8];
         end
      end
      return acc;
   endfunction

endpackage

// File: rtl/uart.sv
// Byte UART core: baud tick generator, 16x-oversampled receiver and transmitter,
// and a small byte FIFO on each direction.
module uart_fifo #(
   parameter int W = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rd,
   input  logic       wr,
   input  logic [7:0] w_data,
   output logic       empty,
   output logic       full,
   output logic [7:0] r_data
);
   localparam int DEPTH = 2 ** W;

   logic [7:0]   mem_r [DEPTH];
   logic [W-1:0] wptr_r;
   logic [W-1:0] rptr_r;
   logic [W:0]   cnt_r;
   logic         wr_en_s;
   logic         rd_en_s;

   assign wr_en_s = wr & ~full;
   assign rd_en_s = rd & ~empty;
   assign empty   = (cnt_r == (W+1)'(0));
   assign full    = (cnt_r == (W+1)'(DEPTH));
   assign r_data  = mem_r[rptr_r];

   // storage array
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
      end else if (wr_en_s) begin
         mem_r[wptr_r] <= w_data;
      end
   end

   // pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_r <= {W{1'b0}};
         rptr_r <= {W{1'b0}};
         cnt_r  <= {(W+1){1'b0}};
      end else begin
         if (wr_en_s) begin
            wptr_r <= wptr_r + W'(1);
         end
         if (rd_en_s) begin
            rptr_r <= rptr_r + W'(1);
         end
         case ({wr_en_s, rd_en_s})
            2'b10:   cnt_r <= cnt_r + (W+1)'(1);
            2'b01:   cnt_r <= cnt_r - (W+1)'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end
endmodule

module uart
   import uart_pkg::*;
#(
   parameter int DVSR     = 54,
   parameter int DVSR_BIT = 7,
   parameter int FIFO_W   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rd_uart,
   input  logic       wr_uart,
   input  logic       rx,
   input  logic [7:0] w_data,
   output logic       tx_full,
   output logic       rx_empty,
   output logic       tx,
   output logic [7:0] r_data
);
   localparam logic [DVSR_BIT-1:0] BAUD_LAST = DVSR_BIT'(DVSR - 1);

   logic [DVSR_BIT-1:0] baud_cnt_r;
   logic                tick_s;
   logic [1:0]          rx_sync_r;
   ser_state_t          rx_state_r;
   logic [3:0]          rx_s_r;
   logic [2:0]          rx_n_r;
   logic [7:0]          rx_b_r;
   logic                rx_done_r;
   logic                rx_full_s;
   ser_state_t          tx_state_r;
   logic [3:0]          tx_s_r;
   logic [2:0]          tx_n_r;
   logic [7:0]          tx_b_r;
   logic                tx_bit_r;
   logic                tx_done_s;
   logic                tx_empty_s;
   logic [7:0]          tx_head_s;

   assign tick_s    = (baud_cnt_r == BAUD_LAST);
   assign tx_done_s = (tx_state_r == S_STOP) && tick_s && (tx_s_r == 4'd15);
   assign tx        = tx_bit_r;

   // 16x oversampling tick
   always_ff @(posedge clk) begin
      if (rst) begin
         baud_cnt_r <= {DVSR_BIT{1'b0}};
      end else if (tick_s) begin
         baud_cnt_r <= {DVSR_BIT{1'b0}};
      end else begin
         baud_cnt_r <= baud_cnt_r + DVSR_BIT'(1);
      end
   end

   // receiver: centre-samples each bit, LSB first
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_sync_r  <= 2'b11;
         rx_state_r <= S_IDLE;
         rx_s_r     <= 4'd0;
         rx_n_r     <= 3'd0;
         rx_b_r     <= 8'h00;
         rx_done_r  <= 1'b0;
      end else begin
         rx_sync_r <= {rx_sync_r[0], rx};
         rx_done_r <= 1'b0;
         case (rx_state_r)
            S_IDLE: begin
               if (!rx_sync_r[1]) begin
                  rx_state_r <= S_START;
                  rx_s_r     <= 4'd0;
               end
            end
            S_START: begin
               if (tick_s) begin
                  if (rx_s_r == 4'd7) begin
                     rx_state_r <= S_DATA;
                     rx_s_r     <= 4'd0;
                     rx_n_r     <= 3'd0;
                  end else begin
                     rx_s_r <= rx_s_r + 4'd1;
                  end
               end
            end
            S_DATA: begin
               if (tick_s) begin
                  if (rx_s_r == 4'd15) begin
                     rx_s_r <= 4'd0;
                     rx_b_r <= {rx_sync_r[1], rx_b_r[7:1]};
                     if (rx_n_r == 3'd7) begin
                        rx_state_r <= S_STOP;
                     end else begin
                        rx_n_r <= rx_n_r + 3'd1;
                     end
                  end else begin
                     rx_s_r <= rx_s_r + 4'd1;
                  end
               end
            end
            S_STOP: begin
               if (tick_s) begin
                  if (rx_s_r == 4'd15) begin
                     rx_state_r <= S_IDLE;
                     rx_done_r  <= 1'b1;
                  end else begin
                     rx_s_r <= rx_s_r + 4'd1;
                  end
               end
            end
            default: rx_state_r <= S_IDLE;
         endcase
      end
   end

   // transmitter: start bit, 8 data bits LSB first, one stop bit
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_r <= S_IDLE;
         tx_s_r     <= 4'd0;
         tx_n_r     <= 3'd0;
         tx_b_r     <= 8'h00;
         tx_bit_r   <= 1'b1;
      end else begin
         case (tx_state_r)
            S_IDLE: begin
               tx_bit_r <= 1'b1;
               if (!tx_empty_s) begin
                  tx_state_r <= S_START;
                  tx_s_r     <= 4'd0;
                  tx_b_r     <= tx_head_s;
                  tx_bit_r   <= 1'b0;
               end
            end
            S_START: begin
               if (tick_s) begin
                  if (tx_s_r == 4'd15) begin
                     tx_state_r <= S_DATA;
                     tx_s_r     <= 4'd0;
                     tx_n_r     <= 3'd0;
                     tx_bit_r   <= tx_b_r[0];
                  end else begin
                     tx_s_r <= tx_s_r + 4'd1;
                  end
               end
            end
            S_DATA: begin
               if (tick_s) begin
                  if (tx_s_r == 4'd15) begin
                     tx_s_r <= 4'd0;
                     tx_b_r <= {1'b0, tx_b_r[7:1]};
                     if (tx_n_r == 3'd7) begin
                        tx_state_r <= S_STOP;
                        tx_bit_r   <= 1'b1;
                     end else begin
                        tx_n_r   <= tx_n_r + 3'd1;
                        tx_bit_r <= tx_b_r[1];
                     end
                  end else begin
                     tx_s_r <= tx_s_r + 4'd1;
                  end
               end
            end
            S_STOP: begin
               if (tick_s) begin
                  if (tx_s_r == 4'd15) begin
                     tx_state_r <= S_IDLE;
                  end else begin
                     tx_s_r <= tx_s_r + 4'd1;
                  end
               end
            end
            default: tx_state_r <= S_IDLE;
         endcase
      end
   end

   uart_fifo #(.W(FIFO_W)) u_rx_fifo (
      .clk    (clk),
      .rst    (rst),
      .rd     (rd_uart),
      .wr     (rx_done_r & ~rx_full_s),
      .w_data (rx_b_r),
      .empty  (rx_empty),
      .full   (rx_full_s),
      .r_data (r_data)
   );

   uart_fifo #(.W(FIFO_W)) u_tx_fifo (
      .clk    (clk),
      .rst    (rst),
      .rd     (tx_done_s),
      .wr     (wr_uart),
      .w_data (w_data),
      .empty  (tx_empty_s),
      .full   (tx_full),
      .r_data (tx_head_s)
   );
endmodule

// File: rtl/uart_packet_ctl_rx.sv
// Receive framing: hunts for the sync header, assembles NBYTES payload bytes,
// verifies the XOR checksum and abandons frames that stall between bytes.
module uart_frame_rx
   import uart_pkg::*;
#(
   parameter int         NBYTES      = 4,
   parameter logic [7:0] HEADER      = DEFAULT_HEADER,
   parameter int         TIMEOUT_CYC = 20000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                byte_valid,
   input  logic [7:0]          byte_data,
   output logic [8*NBYTES-1:0] rx_data,
   output logic                rx_valid,
   output logic                rx_err
);
   localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   rx_state_t           state_r;
   logic [IDX_W-1:0]    idx_r;
   logic [7:0]          csum_r;
   logic [7:0]          buf_r [NBYTES];
   logic [TMO_W-1:0]    tmo_r;
   logic [8*NBYTES-1:0] rx_data_r;
   logic                rx_valid_r;
   logic                rx_err_r;
   logic                tmo_hit_s;

   assign tmo_hit_s = (tmo_r == TMO_LAST);
   assign rx_data   = rx_data_r;
   assign rx_valid  = rx_valid_r;
   assign rx_err    = rx_err_r;

   // frame hunt, assembly and verdict; a byte in the timeout cycle takes priority
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= R_HUNT;
         idx_r      <= {IDX_W{1'b0}};
         csum_r     <= 8'h00;
         tmo_r      <= {TMO_W{1'b0}};
         rx_data_r  <= {(8*NBYTES){1'b0}};
         rx_valid_r <= 1'b0;
         rx_err_r   <= 1'b0;
         for (int k = 0; k < NBYTES; k++) begin
            buf_r[k] <= 8'h00;
         end
      end else begin
         rx_valid_r <= 1'b0;
         rx_err_r   <= 1'b0;
         case (state_r)
            R_HUNT: begin
               tmo_r <= {TMO_W{1'b0}};
               if (byte_valid && (byte_data == HEADER)) begin
                  idx_r   <= {IDX_W{1'b0}};
                  csum_r  <= 8'h00;
                  state_r <= R_PAY;
               end
            end
            R_PAY: begin
               if (byte_valid) begin
                  buf_r[idx_r] <= byte_data;
                  csum_r       <= csum_r ^ byte_data;
                  tmo_r        <= {TMO_W{1'b0}};
                  if (idx_r == IDX_LAST) begin
                     state_r <= R_CSUM;
                  end else begin
                     idx_r <= idx_r + IDX_W'(1);
                  end
               end else if (tmo_hit_s) begin
                  state_r  <= R_HUNT;
                  rx_err_r <= 1'b1;
               end else begin
                  tmo_r <= tmo_r + TMO_W'(1);
               end
            end
            R_CSUM: begin
               if (byte_valid) begin
                  state_r <= R_HUNT;
                  if (byte_data == csum_r) begin
                     for (int k = 0; k < NBYTES; k++) begin
                        rx_data_r[8*k +: 8] <= buf_r[k];
                     end
                     rx_valid_r <= 1'b1;
                  end else begin
                     rx_err_r <= 1'b1;
                  end
               end else if (tmo_hit_s) begin
                  state_r  <= R_HUNT;
                  rx_err_r <= 1'b1;
               end else begin
                  tmo_r <= tmo_r + TMO_W'(1);
               end
            end
            default: state_r <= R_HUNT;
         endcase
      end
   end
endmodule

// File: rtl/uart_packet_ctl.sv
// Framed UART controller: sends header + NBYTES payload + XOR checksum per frame
// and recovers the same frames from the receive side.
module uart_packet_ctl
   import uart_pkg::*;
#(
   parameter int         NBYTES      = 4,
   parameter logic [7:0] HEADER      = DEFAULT_HEADER,
   parameter int         DVSR        = 54,
   parameter int         DVSR_BIT    = 7,
   parameter int         FIFO_W      = 2,
   parameter int         AUTO_TX     = 0,
   parameter int         TIMEOUT_CYC = 20000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rx,
   output logic                tx,
   input  logic [8*NBYTES-1:0] tx_data,
   input  logic                tx_start,
   output logic                tx_busy,
   output logic [8*NBYTES-1:0] rx_data,
   output logic                rx_valid,
   output logic                rx_err
);
   localparam int               IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
   localparam logic             AUTO_S   = (AUTO_TX != 0);

   tx_state_t        tx_state_r;
   logic [7:0]       shadow_r [NBYTES];
   logic [IDX_W-1:0] tx_idx_r;
   logic [7:0]       csum_tx_r;
   logic             tx_busy_r;
   logic             tx_r;
   logic [7:0]       w_data_s;
   logic             wr_uart_s;
   logic             tx_full_s;
   logic             rx_empty_s;
   logic             uart_tx_s;
   logic [7:0]       r_data_s;
   logic             rd_uart_s;

   assign rd_uart_s = ~rx_empty_s;
   assign tx        = tx_r;
   assign tx_busy   = tx_busy_r;

   // byte offered to the TX FIFO in the current state; written only when there is room
   always_comb begin
      w_data_s  = 8'h00;
      wr_uart_s = 1'b0;
      case (tx_state_r)
         T_HDR:   begin w_data_s = HEADER;             wr_uart_s = ~tx_full_s; end
         T_PAY:   begin w_data_s = shadow_r[tx_idx_r]; wr_uart_s = ~tx_full_s; end
         T_CSUM:  begin w_data_s = csum_tx_r;          wr_uart_s = ~tx_full_s; end
         default: begin w_data_s = 8'h00;              wr_uart_s = 1'b0;       end
      endcase
   end

   // TX frame sequencer; payload is snapshotted so mid-frame tx_data changes are harmless
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_r <= T_IDLE;
         tx_idx_r   <= {IDX_W{1'b0}};
         csum_tx_r  <= 8'h00;
         tx_busy_r  <= 1'b0;
         tx_r       <= 1'b1;
         for (int k = 0; k < NBYTES; k++) begin
            shadow_r[k] <= 8'h00;
         end
      end else begin
         tx_r <= uart_tx_s;
         case (tx_state_r)
            T_IDLE: begin
               if (tx_start || AUTO_S) begin
                  for (int k = 0; k < NBYTES; k++) begin
                     shadow_r[k] <= tx_data[8*k +: 8];
                  end
                  csum_tx_r  <= 8'h00;
                  tx_idx_r   <= {IDX_W{1'b0}};
                  tx_busy_r  <= 1'b1;
                  tx_state_r <= T_HDR;
               end
            end
            T_HDR: begin
               if (!tx_full_s) begin
                  tx_state_r <= T_PAY;
               end
            end
            T_PAY: begin
               if (!tx_full_s) begin
                  csum_tx_r <= csum_tx_r ^ w_data_s;
                  if (tx_idx_r == IDX_LAST) begin
                     tx_state_r <= T_CSUM;
                  end else begin
                     tx_idx_r <= tx_idx_r + IDX_W'(1);
                  end
               end
            end
            T_CSUM: begin
               if (!tx_full_s) begin
                  tx_state_r <= T_IDLE;
                  tx_busy_r  <= 1'b0;
               end
            end
            default: begin
               tx_state_r <= T_IDLE;
               tx_busy_r  <= 1'b0;
            end
         endcase
      end
   end

   uart #(
      .DVSR     (DVSR),
      .DVSR_BIT (DVSR_BIT),
      .FIFO_W   (FIFO_W)
   ) u_uart (
      .clk      (clk),
      .rst      (rst),
      .rd_uart  (rd_uart_s),
      .wr_uart  (wr_uart_s),
      .rx       (rx),
      .w_data   (w_data_s),
      .tx_full  (tx_full_s),
      .rx_empty (rx_empty_s),
      .tx       (uart_tx_s),
      .r_data   (r_data_s)
   );

   uart_frame_rx #(
      .NBYTES      (NBYTES),
      .HEADER      (HEADER),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_frame_rx (
      .clk        (clk),
      .rst        (rst),
      .byte_valid (rd_uart_s),
      .byte_data  (r_data_s),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_err     (rx_err)
   );
endmodule

// File: tb/tb_uart_packet_ctl.sv
// Scoreboard bench for uart_packet_ctl: serial TX decoder and RX event monitor
// pop expected bytes/events queued by the directed stimulus.
module tb_uart_packet_ctl;
   localparam int BIT = 64;   // 16 ticks x DVSR=4

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } rx_exp_t;

   logic        clk = 1'b0;
   logic        rst, a_rst, loop_en, inj, tx_start, tx_chk_en;
   logic [31:0] tx_data;
   logic        rx_line, tx, tx_busy, rx_valid, rx_err;
   logic [31:0] rx_data;
   logic        a_tx, a_busy, a_valid, a_err;
   logic [31:0] a_data;

   int          total = 0;
   int          bad   = 0;
   int          a_cnt = 0;
   logic [7:0]  tx_q[$];
   rx_exp_t     rx_q[$];

   always #5 clk = ~clk;
   assign rx_line = loop_en ? tx : inj;

   uart_packet_ctl #(
      .NBYTES(4), .HEADER(8'hA5), .DVSR(4), .DVSR_BIT(3),
      .FIFO_W(2), .AUTO_TX(0), .TIMEOUT_CYC(2000)
   ) dut (
      .clk(clk), .rst(rst), .rx(rx_line), .tx(tx), .tx_data(tx_data),
      .tx_start(tx_start), .tx_busy(tx_busy), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_err(rx_err)
   );

   uart_packet_ctl #(
      .NBYTES(4), .HEADER(8'hA5), .DVSR(4), .DVSR_BIT(3),
      .FIFO_W(2), .AUTO_TX(1), .TIMEOUT_CYC(2000)
   ) dut_auto (
      .clk(clk), .rst(a_rst), .rx(a_tx), .tx(a_tx), .tx_data(32'hCAFE0102),
      .tx_start(1'b0), .tx_busy(a_busy), .rx_data(a_data),
      .rx_valid(a_valid), .rx_err(a_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      inj = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         inj = b[i];
         repeat (BIT) @(negedge clk);
      end
      inj = 1'b1;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic pulse_start();
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((tx_q.size() != 0 || rx_q.size() != 0 || tx_busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= budget) begin
         bad++;
         $display("FAIL %s: timed out with %0d tx bytes and %0d rx events still expected",
                  name, tx_q.size(), rx_q.size());
      end
      repeat (4 * BIT) @(negedge clk);
   endtask

   // serial decoder on the main tx line
   initial begin : tx_mon
      logic [7:0] b;
      logic       stop_bit;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            repeat (BIT / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BIT) @(negedge clk);
               b[i] = tx;
            end
            repeat (BIT) @(negedge clk);
            stop_bit = tx;
            if (tx_chk_en) begin
               check("tx_stop_bit", {31'd0, stop_bit}, 32'd1);
               if (tx_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL tx_unexpected: got byte %h want no byte", b);
               end else begin
                  check("tx_byte", {24'd0, b}, {24'd0, tx_q.pop_front()});
               end
            end
         end
      end
   end

   // RX event monitor on the main instance
   initial begin : rx_mon
      rx_exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && (rx_valid || rx_err)) begin
            check("rx_exclusive", {31'd0, rx_valid & rx_err}, 32'd0);
            if (rx_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rx_unexpected: got valid=%0b err=%0b data=%h want no event",
                        rx_valid, rx_err, rx_data);
            end else begin
               e = rx_q.pop_front();
               check("rx_kind_err", {31'd0, rx_err}, {31'd0, e.err});
               check("rx_data", rx_data, e.data);
            end
         end
      end
   end

   // auto-repeat instance: every frame must arrive intact and back-to-back
   initial begin : auto_mon
      int gap = 0;
      forever begin
         @(negedge clk);
         if (!a_rst) begin
            gap++;
            if (a_valid || a_err) begin
               check("auto_err", {31'd0, a_err}, 32'd0);
               check("auto_data", a_data, 32'hCAFE0102);
               if (a_cnt > 0) begin
                  check("auto_gap", {31'd0, gap <= 4200}, 32'd1);
               end
               a_cnt++;
               gap = 0;
            end
         end
      end
   end

   initial begin : watchdog
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: got no end of test within 90000 cycles want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      rst = 1'b1; a_rst = 1'b1; loop_en = 1'b0; inj = 1'b1;
      tx_start = 1'b0; tx_data = 32'h0; tx_chk_en = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, tx_busy}, 32'd0);
      check("rst_rx_data", rx_data, 32'd0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_rx_err", {31'd0, rx_err}, 32'd0);
      rst = 1'b0; a_rst = 1'b0;

      // loopback frame; second start and new data while busy must be ignored
      loop_en = 1'b1;
      tx_data = 32'h12345678;
      tx_q.push_back(8'hA5); tx_q.push_back(8'h78); tx_q.push_back(8'h56);
      tx_q.push_back(8'h34); tx_q.push_back(8'h12); tx_q.push_back(8'h08);
      rx_q.push_back({1'b0, 32'h12345678});
      pulse_start();
      check("busy_after_start", {31'd0, tx_busy}, 32'd1);
      tx_data = 32'hDEADBEEF;
      pulse_start();
      n = 0;
      while (tx_busy && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("busy_drop_bytes_pending", tx_q.size(), 32'd4);
      wait_idle("loopback_frame", 20000);

      // bad checksum: error pulse, rx_data keeps the last good payload
      loop_en = 1'b0;
      rx_q.push_back({1'b1, 32'h12345678});
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
      send_byte(8'h03); send_byte(8'h04); send_byte(8'hFF);
      wait_idle("bad_csum", 4000);

      // leading garbage skipped, header value accepted as payload data
      rx_q.push_back({1'b0, 32'hA5A5A5A5});
      send_byte(8'h00); send_byte(8'hA5); send_byte(8'hA5); send_byte(8'hA5);
      send_byte(8'hA5); send_byte(8'hA5); send_byte(8'h00);
      wait_idle("hdr_as_data", 4000);

      // stalled frame times out, next good frame still accepted
      rx_q.push_back({1'b1, 32'hA5A5A5A5});
      send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22);
      wait_idle("timeout", 3000);
      rx_q.push_back({1'b0, 32'h0BADF00D});
      send_byte(8'hA5); send_byte(8'h0D); send_byte(8'hF0);
      send_byte(8'hAD); send_byte(8'h0B); send_byte(8'h5B);
      wait_idle("after_timeout", 4000);

      // reset mid-frame on both directions: nothing may complete
      loop_en = 1'b1;
      tx_chk_en = 1'b0;
      tx_data = 32'h11223344;
      pulse_start();
      repeat (25 * BIT) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_tx", {31'd0, tx}, 32'd1);
      check("midrst_busy", {31'd0, tx_busy}, 32'd0);
      check("midrst_rx_data", rx_data, 32'd0);
      check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("midrst_rx_err", {31'd0, rx_err}, 32'd0);
      rst = 1'b0;
      repeat (15 * BIT) @(negedge clk);
      check("midrst_no_rx_event", rx_q.size(), 32'd0);
      check("midrst_rx_data_hold", rx_data, 32'd0);
      tx_q.delete();
      tx_chk_en = 1'b1;

      // recovery frame after reset
      tx_data = 32'h01020304;
      tx_q.push_back(8'hA5); tx_q.push_back(8'h04); tx_q.push_back(8'h03);
      tx_q.push_back(8'h02); tx_q.push_back(8'h01); tx_q.push_back(8'h04);
      rx_q.push_back({1'b0, 32'h01020304});
      pulse_start();
      wait_idle("recovery_frame", 20000);

      check("auto_frames_seen", {31'd0, a_cnt >= 3}, 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
